mem_port_sequencer: RTL
=======================

Name: mem_port_sequencer

Overview:
- Sequences and arbitrates the single MOV/MOC RAM port between two requesters: the instruction-fetch path (IR load) and the load/store data path (MDR).
- Latches the winning request, drives the RAM control and address lines, waits for MOC and returns read data with a one-cycle done pulse.
- Sits between the control unit / MAR / MDR and the ram module.
- Includes a watchdog so a missing MOC cannot hang the control unit.

Parameters:
- ADDR_W, 32, width of the address bus.
- DATA_W, 32, width of the data bus.
- TIMEOUT, 16, maximum number of ACCESS cycles to wait for MOC; legal range 2..255.

Ports:
- clk  in  1  system clock; rising edge.
- clr  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request; held high until f_done.
- f_addr  in  ADDR_W  fetch address (PC).
- d_req  in  1  data request; held high until d_done.
- d_addr  in  ADDR_W  data address (MAR).
- d_wdata  in  DATA_W  store data (MDR).
- d_rw  in  1  1 = read, 0 = write.
- d_dtype  in  2  data type: byte, half, or word.
- d_sign  in  1  sign-extend a load.
- f_done  out  1  one-cycle pulse when the fetch access completes.
- d_done  out  1  one-cycle pulse when the data access completes.
- rdata  out  DATA_W  captured read data; valid with done, held until the next capture.
- err  out  1  MOC timeout flag, qualified by done.
- busy  out  1  high in ACCESS and DONE states.
- mem_mov  out  1  memory operation valid.
- mem_rw  out  1  RAM read/write select.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_dtype  out  2  RAM data type.
- mem_sign  out  1  RAM sign control.
- mem_moc  in  1  memory operation complete.
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (clr low, asynchronous):
  - State goes to IDLE.
  - All outputs 0, latched registers 0, watchdog counter 0.
  - Arbitration pointer set to fetch.
- IDLE:
  - mem_mov = 0.
  - If any request is high, choose a winner and latch its addr, wdata, rw, dtype and sign, clear the counter, then go to ACCESS.
  - Fetch requests always latch rw = 1, dtype = 2'b10 (word), sign = 0, wdata = 0.
- ACCESS:
  - mem_mov = 1; mem_* are driven only from latched registers, so they are stable for the whole access.
  - On a clock edge with mem_moc = 1: capture mem_rdata into rdata (read accesses only; writes leave rdata unchanged), set err = 0, go to DONE.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 with no MOC: set err = 1, leave rdata unchanged, go to DONE.
- DONE:
  - mem_mov = 0.
  - Pulse the winner's done for exactly one cycle, then go to IDLE.
  - err holds its value until the next capture.
- Latency:
  - Request high at edge N, MOC already high at edge N+1: done is high in cycle N+2.
  - Minimum occupancy is 3 cycles per access; back-to-back requests start again from IDLE.
- Requester rules:
  - A requester deasserting req mid-access does not abort; the access completes and its done still pulses.
  - Changes to request-side inputs after the latch are ignored.
- Fixed-priority arbitration (default): when both requests are high, data wins over fetch.
- mem_moc while in IDLE or DONE is ignored.
- busy = 1 in ACCESS and DONE.
- Reset mid-access: mem_mov drops immediately (asynchronous), no done is produced, and the requester must re-issue.

Optional Feature:
- Macro: MEM_PORT_RR_ARB_EN.
- Defined: round-robin arbitration. A one-bit last-winner pointer updates in DONE; when both requests are high, the requester that did not win last gets the grant. The pointer resets to fetch, so data wins the first tie after reset.
- Undefined: fixed priority (data over fetch); the pointer logic is absent.

Test Plan:
- Fetch only: f_req = 1, f_addr = 0x40, RAM returns MOC 2 cycles after mov with data 0x8210_0005 -> mem_addr = 0x40, mem_rw = 1, mem_dtype = 2'b10; f_done pulses once; rdata = 0x8210_0005; err = 0.
- Store: d_req = 1, d_rw = 0, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, d_dtype = 2'b00 -> mem_wdata = 0xDEAD_BEEF and mem_dtype = 2'b00 held stable through ACCESS; d_done pulses; rdata unchanged.
- Simultaneous requests, macro off -> data access served first, then fetch; fetch served without any gap beyond IDLE; exactly two done pulses.
- Simultaneous requests held over 4 accesses, macro on -> grant order data, fetch, data, fetch.
- MOC never asserted, TIMEOUT = 16 -> mem_mov high for exactly 16 cycles; done pulses with err = 1; next access with a normal MOC clears err.
- clr pulled low during ACCESS -> mem_mov = 0 in the same cycle, no done pulse; after release, a new request completes normally.

Source files
------------

// File: rtl/mem_port_sequencer.sv
// Arbitrates and sequences the single MOV/MOC RAM port between instruction fetch and data access.
// Define MEM_PORT_RR_ARB_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_port_sequencer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_rw,
  input  logic [1:0]        d_dtype,
  input  logic              d_sign,
  output logic              f_done,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_dtype,
  output logic              mem_sign,
  input  logic              mem_moc,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [7:0] CntMax    = 8'(TIMEOUT - 1);
  localparam logic [1:0] DtypeWord = 2'b10;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                win_q, win_d;  // 1: data owns the current access
  logic                mem_mov_q, mem_mov_d;
  logic                mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          mem_dtype_q, mem_dtype_d;
  logic                mem_sign_q, mem_sign_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                f_done_q, f_done_d;
  logic                d_done_q, d_done_d;
  logic                busy_q, busy_d;
  logic                grant_data;
  logic                finish;

`ifdef MEM_PORT_RR_ARB_EN
  logic                last_q, last_d;  // 1: data won the previous access

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_data = d_req & (~f_req | ~last_q);
  end
`else
  always_comb begin
    grant_data = d_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    mem_mov_d   = mem_mov_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_dtype_d = mem_dtype_q;
    mem_sign_d  = mem_sign_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    busy_d      = busy_q;
    f_done_d    = 1'b0;
    d_done_d    = 1'b0;
    finish      = 1'b0;
`ifdef MEM_PORT_RR_ARB_EN
    last_d      = last_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (f_req | d_req) begin
          win_d = grant_data;
          if (grant_data) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_rw_d    = d_rw;
            mem_dtype_d = d_dtype;
            mem_sign_d  = d_sign;
          end else begin
            mem_addr_d  = f_addr;
            mem_wdata_d = '0;
            mem_rw_d    = 1'b1;
            mem_dtype_d = DtypeWord;
            mem_sign_d  = 1'b0;
          end
          cnt_d     = '0;
          mem_mov_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = StAccess;
        end
      end

      StAccess: begin
        // MOC on the last permitted cycle still counts as a normal completion.
        if (mem_moc) begin
          if (mem_rw_q) begin
            rdata_d = mem_rdata;
          end
          err_d  = 1'b0;
          finish = 1'b1;
        end else if (cnt_q == CntMax) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end

        if (finish) begin
          mem_mov_d = 1'b0;
          f_done_d  = ~win_q;
          d_done_d  = win_q;
          state_d   = StDone;
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
`ifdef MEM_PORT_RR_ARB_EN
        last_d  = win_q;
`endif
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      win_q       <= 1'b0;
      mem_mov_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_dtype_q <= '0;
      mem_sign_q  <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_PORT_RR_ARB_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      mem_mov_q   <= mem_mov_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_dtype_q <= mem_dtype_d;
      mem_sign_q  <= mem_sign_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
`ifdef MEM_PORT_RR_ARB_EN
      last_q      <= last_d;
`endif
    end
  end

  assign f_done    = f_done_q;
  assign d_done    = d_done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_mov   = mem_mov_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_dtype = mem_dtype_q;
  assign mem_sign  = mem_sign_q;

  a_done_onehot: assert property (@(posedge clk) disable iff (!clr) !(f_done_q && d_done_q));
  a_mov_busy:    assert property (@(posedge clk) disable iff (!clr) !mem_mov_q || busy_q);

endmodule
